// File: rtl/ts_packet_mux.sv
// Merges NUM_CH TS byte streams packet by packet: hunts a sync byte round-robin, then moves a whole packet.
// One cycle pop-to-output latency; the head channel is popped only when the output register is free or accepted.
module ts_packet_mux #(
   parameter int                    NUM_CH     = 4,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    PKT_LEN    = 188,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(8'h47)
) (
   input  logic                         rclk,
   input  logic                         reset_n,
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]            ch_pop,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(NUM_CH)-1:0]    out_ch,
   output logic                         out_sop,
   output logic                         out_eop,
   output logic [NUM_CH*16-1:0]         discard_cnt,
   output logic [31:0]                  pkt_cnt
);

   localparam int             CW   = $clog2(NUM_CH);
   localparam int             BW   = $clog2(PKT_LEN);
   localparam logic [BW-1:0]  LAST = BW'(PKT_LEN - 1);
   localparam logic [CW-1:0]  TOP  = CW'(NUM_CH - 1);

   typedef enum logic {HUNT, XFER} state_t;

   state_t                  state;
   logic [CW-1:0]           grant;
   logic [CW-1:0]           rr_ptr;
   logic [BW-1:0]           byte_cnt;
   logic [DATA_WIDTH-1:0]   head [NUM_CH];
   logic [15:0]             disc [NUM_CH];
   logic [NUM_CH-1:0]       is_sync;
   logic [NUM_CH-1:0]       is_junk;
   logic                    hunt_hit;
   logic [CW-1:0]           hunt_idx;
   logic [CW-1:0]           pos;
   logic                    out_free;
   logic                    xfer_pop;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign head[i]                = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign is_sync[i]             = ch_valid[i] && (head[i] == SYNC_BYTE);
      assign discard_cnt[i*16 +: 16] = disc[i];
   end

   assign is_junk  = ch_valid & ~is_sync;
   assign out_free = !out_valid || out_ready;
   assign xfer_pop = (state == XFER) && ch_valid[grant] && out_free;

   // Walk from the farthest candidate back to rr_ptr so the nearest sync channel wins.
   always_comb begin
      hunt_hit = 1'b0;
      hunt_idx = '0;
      pos      = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         pos = CW'((int'(rr_ptr) + k) % NUM_CH);
         if (is_sync[pos]) begin
            hunt_hit = 1'b1;
            hunt_idx = pos;
         end
      end
   end

   // Sync-headed channels are never popped while hunting; the byte is taken later as byte 0.
   always_comb begin
      ch_pop = '0;
      if (reset_n) begin
         if (state == HUNT) begin
            ch_pop = is_junk;
         end else begin
            ch_pop[grant] = out_free;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (!reset_n) begin
         state     <= HUNT;
         grant     <= '0;
         rr_ptr    <= '0;
         byte_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         pkt_cnt   <= '0;
      end else begin
         case (state)
            HUNT: begin
               if (hunt_hit) begin
                  grant    <= hunt_idx;
                  byte_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (xfer_pop) begin
                  if (byte_cnt == LAST) begin
                     state    <= HUNT;
                     byte_cnt <= '0;
                     rr_ptr   <= (grant == TOP) ? '0 : grant + CW'(1);
                  end else begin
                     byte_cnt <= byte_cnt + BW'(1);
                  end
               end
            end
            default: state <= HUNT;
         endcase

         if (xfer_pop) begin
            out_valid <= 1'b1;
            out_data  <= head[grant];
            out_ch    <= grant;
            out_sop   <= (byte_cnt == '0);
            out_eop   <= (byte_cnt == LAST);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (out_valid && out_ready && out_eop) begin
            pkt_cnt <= pkt_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) disc[i] <= '0;
      end else if (state == HUNT) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (is_junk[i] && (disc[i] != 16'hFFFF)) disc[i] <= disc[i] + 16'd1;
         end
      end
   end

endmodule
